// File: rtl/fl_pkg.sv
// Shared configuration and types for the checkpointed physical-register free list.
// Widths are derived here so every consumer agrees on pointer and tag sizes.
package fl_pkg;
    localparam int N_PREG = 64;
    localparam int N_ARCH = 32;
    localparam int N_WAY  = 2;
    localparam int N_CKPT = 4;

    localparam int PREG_W = $clog2(N_PREG);
    localparam int N_FREE = N_PREG - N_ARCH;
    localparam int IDX_W  = $clog2(N_FREE);
    localparam int PTR_W  = IDX_W + 1;
    localparam int NUM_W  = $clog2(N_WAY) + 1;
    localparam int CKID_W = $clog2(N_CKPT);

    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [PTR_W-1:0]  fl_ptr_t;

    localparam preg_t ZERO_PR = '0;
endpackage

// File: rtl/fl_ckpt_regs.sv
// Branch checkpoint slots: one write port for checkpoint capture, one
// combinational read port for mispredict recovery (reads see the pre-edge value).
module fl_ckpt_regs #(
    parameter int SLOTS = 4,
    parameter int W     = 6
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     take,
    input  logic [$clog2(SLOTS)-1:0] take_id,
    input  logic [W-1:0]             take_ptr,
    input  logic [$clog2(SLOTS)-1:0] rd_id,
    output logic [W-1:0]             rd_ptr
);
    logic [W-1:0] slot [SLOTS];

    assign rd_ptr = slot[rd_id];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SLOTS; i++) begin
                slot[i] <= '0;
            end
        end else if (take) begin
            slot[take_id] <= take_ptr;
        end
    end
endmodule

// File: rtl/free_list_ckpt.sv
// Circular-FIFO free list of physical registers for rename, with head-pointer
// checkpoints for branch recovery and a full flush for exceptions.
module free_list_ckpt
    import fl_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_W-1:0]       alloc_num,
    output logic                   alloc_gnt,
    output preg_t [N_WAY-1:0]      alloc_tag,
    output logic [NUM_W-1:0]       free_num,
    output logic [PTR_W-1:0]       free_count,
    input  logic [N_WAY-1:0]       rel_valid,
    input  preg_t [N_WAY-1:0]      rel_tag,
    input  logic                   ckpt_take,
    input  logic [CKID_W-1:0]      ckpt_id,
    input  logic                   restore,
    input  logic [CKID_W-1:0]      restore_id,
    input  logic                   flush,
    output logic                   ovf_err
);
    preg_t                        mem [N_FREE];
    fl_ptr_t                      head, tail;
    fl_ptr_t                      head_next, tail_next;
    fl_ptr_t                      ckpt_ptr, space, rel_cnt;
    logic [N_WAY-1:0]             wr_en;
    logic [N_WAY-1:0][IDX_W-1:0]  wr_idx;
    logic                         ovf_now;

    // Handshake: alloc_num is the request and alloc_gnt the all-or-nothing grant;
    // head advances by alloc_num only on a granted cycle, otherwise nothing is consumed.
    assign free_count = tail - head;
    assign alloc_gnt  = (PTR_W'(alloc_num) <= free_count) && !restore && !flush;
    assign free_num   = (free_count >= PTR_W'(N_WAY)) ? NUM_W'(N_WAY) : free_count[NUM_W-1:0];

    always_comb begin
        for (int k = 0; k < N_WAY; k++) begin
            alloc_tag[k] = (k < int'(alloc_num)) ? mem[IDX_W'(head + fl_ptr_t'(k))] : ZERO_PR;
        end
    end

    // Releases are packed at tail in lane order; anything past a full list is dropped.
    always_comb begin
        rel_cnt = '0;
        ovf_now = 1'b0;
        wr_en   = '0;
        wr_idx  = '0;
        space   = fl_ptr_t'(N_FREE) - free_count;
        for (int k = 0; k < N_WAY; k++) begin
            if (rel_valid[k] && (rel_tag[k] != ZERO_PR)) begin
                if (rel_cnt < space) begin
                    wr_en[k]  = 1'b1;
                    wr_idx[k] = IDX_W'(tail + rel_cnt);
                    rel_cnt   = rel_cnt + fl_ptr_t'(1);
                end else begin
                    ovf_now = 1'b1;
                end
            end
        end
        tail_next = tail + rel_cnt;
    end

    always_comb begin
        head_next = head;
        if (flush) begin
            head_next = tail_next - fl_ptr_t'(N_FREE);
        end else if (restore) begin
            head_next = ckpt_ptr;
        end else if (alloc_gnt) begin
            head_next = head + fl_ptr_t'(alloc_num);
        end
    end

    fl_ckpt_regs #(
        .SLOTS (N_CKPT),
        .W     (PTR_W)
    ) u_ckpt (
        .clock    (clock),
        .reset    (reset),
        .take     (ckpt_take && !flush),
        .take_id  (ckpt_id),
        .take_ptr (head_next),
        .rd_id    (restore_id),
        .rd_ptr   (ckpt_ptr)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            head    <= '0;
            tail    <= fl_ptr_t'(N_FREE);
            ovf_err <= 1'b0;
            for (int i = 0; i < N_FREE; i++) begin
                mem[i] <= preg_t'(N_ARCH + i);
            end
        end else begin
            head <= head_next;
            tail <= tail_next;
            if (ovf_now) begin
                ovf_err <= 1'b1;
            end
            for (int k = 0; k < N_WAY; k++) begin
                if (wr_en[k]) begin
                    mem[wr_idx[k]] <= rel_tag[k];
                end
            end
        end
    end
endmodule

// File: tb/tb_free_list_ckpt.sv
// Bench for free_list_ckpt: a reset-relative vector table, directed corner
// sequences, then randomized traffic against a tag-log reference model.
module tb_free_list_ckpt;
    import fl_pkg::*;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [NUM_W-1:0]      alloc_num;
    logic                  alloc_gnt;
    preg_t [N_WAY-1:0]     alloc_tag;
    logic [NUM_W-1:0]      free_num;
    logic [PTR_W-1:0]      free_count;
    logic [N_WAY-1:0]      rel_valid;
    preg_t [N_WAY-1:0]     rel_tag;
    logic                  ckpt_take;
    logic [CKID_W-1:0]     ckpt_id;
    logic                  restore;
    logic [CKID_W-1:0]     restore_id;
    logic                  flush;
    logic                  ovf_err;

    always #5 clock = ~clock;

    free_list_ckpt dut (
        .clock      (clock),
        .reset      (reset),
        .alloc_num  (alloc_num),
        .alloc_gnt  (alloc_gnt),
        .alloc_tag  (alloc_tag),
        .free_num   (free_num),
        .free_count (free_count),
        .rel_valid  (rel_valid),
        .rel_tag    (rel_tag),
        .ckpt_take  (ckpt_take),
        .ckpt_id    (ckpt_id),
        .restore    (restore),
        .restore_id (restore_id),
        .flush      (flush),
        .ovf_err    (ovf_err)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int         an;
        logic [1:0] rv;
        int         t0;
        int         t1;
        logic       g;
        int         e0;
        int         e1;
        int         cnt;
    } vec_t;

    vec_t tbl[8];

    // Reference model: an ever-growing log of every tag entered into the list,
    // with absolute head position; the free list is log[m_head .. size-1].
    int log_q[$];
    int m_head;
    int m_slot[N_CKPT];
    bit m_ovf;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input int an, input logic [1:0] rv, input int t0, input int t1,
                         input logic ct, input int cid, input logic rs, input int rid,
                         input logic fl);
        alloc_num  = NUM_W'(an);
        rel_valid  = rv;
        rel_tag[0] = preg_t'(t0);
        rel_tag[1] = preg_t'(t1);
        ckpt_take  = ct;
        ckpt_id    = CKID_W'(cid);
        restore    = rs;
        restore_id = CKID_W'(rid);
        flush      = fl;
    endtask

    task automatic idle();
        drive(0, 2'b00, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    // A negative expected tag means the lane is not checked (stale storage).
    task automatic expect_out(input string nm, input logic g, input int tg0, input int tg1,
                              input int cnt, input logic ov);
        @(negedge clock);
        chk({nm, ".gnt"}, 32'(alloc_gnt), 32'(g));
        if (tg0 >= 0) chk({nm, ".tag0"}, 32'(alloc_tag[0]), tg0);
        if (tg1 >= 0) chk({nm, ".tag1"}, 32'(alloc_tag[1]), tg1);
        chk({nm, ".count"}, 32'(free_count), cnt);
        chk({nm, ".num"}, 32'(free_num), (cnt > N_WAY) ? N_WAY : cnt);
        chk({nm, ".ovf"}, 32'(ovf_err), 32'(ov));
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        step();
        reset = 1'b0;
    endtask

    task automatic model_reset();
        log_q.delete();
        for (int i = 0; i < N_FREE; i++) log_q.push_back(N_ARCH + i);
        m_head = 0;
        for (int i = 0; i < N_CKPT; i++) m_slot[i] = 0;
        m_ovf = 1'b0;
    endtask

    task automatic model_step(input int an, input logic [1:0] rv, input int t0, input int t1,
                              input logic ct, input int cid, input logic rs, input int rid,
                              input logic fl);
        int cnt, acc, nh;
        int tg[2];
        bit g;
        tg[0] = t0;
        tg[1] = t1;
        cnt = log_q.size() - m_head;
        g   = (an <= cnt) && !rs && !fl;
        acc = 0;
        for (int k = 0; k < N_WAY; k++) begin
            if (rv[k] && tg[k] != 0) begin
                if (cnt + acc < N_FREE) begin
                    log_q.push_back(tg[k]);
                    acc++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        if (fl)      nh = log_q.size() - N_FREE;
        else if (rs) nh = m_slot[rid];
        else if (g)  nh = m_head + an;
        else         nh = m_head;
        if (ct && !fl) m_slot[cid] = nh;
        m_head = nh;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        step();
        reset = 1'b0;

        tbl[0] = '{0, 2'b00, 0, 0, 1'b1, 0,  0,  32};
        tbl[1] = '{2, 2'b00, 0, 0, 1'b1, 32, 33, 32};
        tbl[2] = '{1, 2'b00, 0, 0, 1'b1, 34, 0,  30};
        tbl[3] = '{0, 2'b11, 5, 6, 1'b1, 0,  0,  29};
        tbl[4] = '{2, 2'b00, 0, 0, 1'b1, 35, 36, 31};
        tbl[5] = '{0, 2'b10, 3, 7, 1'b1, 0,  0,  29};
        tbl[6] = '{2, 2'b01, 0, 9, 1'b1, 37, 38, 30};
        tbl[7] = '{0, 2'b00, 0, 0, 1'b1, 0,  0,  28};
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].an, tbl[i].rv, tbl[i].t0, tbl[i].t1, 1'b0, 0, 1'b0, 0, 1'b0);
            expect_out($sformatf("vec%0d", i), tbl[i].g, tbl[i].e0, tbl[i].e1, tbl[i].cnt, 1'b0);
            step();
        end

        // Drain to one entry, refuse an oversize request, then take the last tag.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive(2, 2'b00, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
            step();
        end
        drive(1, 2'b00, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
        expect_out("drain_62", 1'b1, 62, 0, 2, 1'b0);
        step();
        drive(2, 2'b00, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
        expect_out("deny_2", 1'b0, -1, -1, 1, 1'b0);
        step();
        drive(1, 2'b00, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
        expect_out("last_63", 1'b1, 63, 0, 1, 1'b0);
        step();
        drive(1, 2'b00, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
        expect_out("empty", 1'b0, -1, -1, 0, 1'b0);
        step();

        // From empty: zero tag on lane 1 is skipped; the released tag is visible next cycle only.
        drive(0, 2'b11, 5, 0, 1'b0, 0, 1'b0, 0, 1'b0);
        expect_out("rel_zero", 1'b1, 0, 0, 0, 1'b0);
        step();
        drive(1, 2'b00, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
        expect_out("realloc_5", 1'b1, 5, 0, 1, 1'b0);
        step();
        idle();
        expect_out("after_5", 1'b1, 0, 0, 0, 1'b0);
        step();

        // Checkpoint after the branch's own allocation, then recover to it.
        do_reset();
        drive(2, 2'b00, 0, 0, 1'b1, 1, 1'b0, 0, 1'b0);
        expect_out("ck_take", 1'b1, 32, 33, 32, 1'b0);
        step();
        drive(2, 2'b00, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
        expect_out("ck_more", 1'b1, 34, 35, 30, 1'b0);
        step();
        drive(2, 2'b00, 0, 0, 1'b0, 0, 1'b1, 1, 1'b0);
        expect_out("ck_restore", 1'b0, -1, -1, 28, 1'b0);
        step();
        drive(2, 2'b00, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
        expect_out("ck_after", 1'b1, 34, 35, 30, 1'b0);
        step();

        // Flush with a same-cycle release returns the list to full.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(2, 2'b00, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
            step();
        end
        drive(2, 2'b01, 7, 0, 1'b0, 0, 1'b0, 0, 1'b1);
        expect_out("flush", 1'b0, -1, -1, 26, 1'b0);
        step();
        idle();
        expect_out("flush_after", 1'b1, 0, 0, 32, 1'b0);
        step();

        // Release into a full list: dropped, sticky error until reset.
        drive(0, 2'b01, 9, 0, 1'b0, 0, 1'b0, 0, 1'b0);
        expect_out("ovf_rel", 1'b1, 0, 0, 32, 1'b0);
        step();
        idle();
        expect_out("ovf_set", 1'b1, 0, 0, 32, 1'b1);
        step();
        idle();
        expect_out("ovf_hold", 1'b1, 0, 0, 32, 1'b1);
        step();
        do_reset();
        idle();
        expect_out("ovf_clr", 1'b1, 0, 0, 32, 1'b0);

        // Randomized traffic against the log model.
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int an, t0, t1, cid, rid, cnt, tl;
            logic [1:0] rv;
            logic ct, rs, fl, rst;
            tl  = log_q.size();
            cnt = tl - m_head;
            an  = $urandom_range(0, 2);
            rv  = 2'($urandom_range(0, 3));
            if (cnt > 28 && $urandom_range(0, 3) != 0) rv = 2'b00;
            t0  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, N_PREG - 1);
            t1  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, N_PREG - 1);
            ct  = ($urandom_range(0, 5) == 0);
            cid = $urandom_range(0, N_CKPT - 1);
            rid = $urandom_range(0, N_CKPT - 1);
            fl  = ($urandom_range(0, 49) == 0);
            rs  = 1'b0;
            if (!fl && $urandom_range(0, 9) == 0 && m_slot[rid] <= tl && tl - m_slot[rid] <= N_FREE) begin
                rs = 1'b1;
                rv = 2'b00;
            end
            rst = ($urandom_range(0, 499) == 0);
            drive(an, rv, t0, t1, ct, cid, rs, rid, fl);
            reset = rst;
            @(negedge clock);
            if (!rst) begin
                chk("rnd.gnt", 32'(alloc_gnt), 32'((an <= cnt) && !rs && !fl));
                chk("rnd.count", 32'(free_count), cnt);
                chk("rnd.num", 32'(free_num), (cnt > N_WAY) ? N_WAY : cnt);
                chk("rnd.ovf", 32'(ovf_err), 32'(m_ovf));
                for (int k = 0; k < N_WAY; k++) begin
                    if (k >= an) chk("rnd.tag_idle", 32'(alloc_tag[k]), 0);
                    else if (m_head + k < tl) chk("rnd.tag", 32'(alloc_tag[k]), log_q[m_head + k]);
                end
                model_step(an, rv, t0, t1, ct, cid, rs, rid, fl);
            end else begin
                model_reset();
            end
            step();
            reset = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/free_list_ckpt.md
Name: free_list_ckpt

Overview:
- Circular-FIFO physical-register free list for the out-of-order core's rename stage.
- Generalises the bitmap free list to parametrised register-file size, dispatch width and retire width.
- Adds multi-checkpoint branch recovery (restore any of N_CKPT saved head pointers) and full exception flush.
- Sits between dispatch/rename (allocate) and ROB retire (release of Told).

Parameters:
- N_PREG, 64, number of physical registers; N_PREG-N_ARCH must be a power of two.
- N_ARCH, 32, architectural registers; tags 0..N_ARCH-1 are mapped at reset.
- N_WAY, 2, allocate lanes and release lanes per cycle.
- N_CKPT, 4, branch checkpoint slots.
- ZERO_PR, 0, tag that is never released or allocated.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- alloc_num  in  clog2(N_WAY)+1  lanes requested this cycle (low lanes first).
- alloc_gnt  out  1  request granted; all-or-nothing.
- alloc_tag  out  N_WAY x PREG_W  tags for lanes 0..alloc_num-1; lanes >= alloc_num drive 0.
- free_num  out  clog2(N_WAY)+1  min(free_count, N_WAY).
- free_count  out  clog2(N_FREE)+1  entries currently in the list.
- rel_valid  in  N_WAY  release lane valid (retired Told).
- rel_tag  in  N_WAY x PREG_W  released tags.
- ckpt_take  in  1  save the head pointer into slot ckpt_id.
- ckpt_id  in  clog2(N_CKPT)  slot written by ckpt_take.
- restore  in  1  branch mispredict; restore head from slot restore_id.
- restore_id  in  clog2(N_CKPT)  slot read by restore.
- flush  in  1  exception; return all speculative allocations.
- ovf_err  out  1  sticky; a release would exceed N_FREE entries.

Behaviour:
- N_FREE = N_PREG-N_ARCH; storage is N_FREE x PREG_W.
- head and tail are clog2(N_FREE)+1 bits (extra bit is the wrap bit).
- free_count = tail - head, modulo 2^(clog2(N_FREE)+1).
- Reset:
  - entry i = N_ARCH+i; head=0; tail=N_FREE (wrap bit set, index 0); free_count=N_FREE.
  - ovf_err=0; all checkpoint slots = 0.
- Allocate:
  - alloc_tag[k] = entry[(head+k) mod N_FREE], read combinationally from registered storage.
  - alloc_gnt = (alloc_num <= free_count) && !restore && !flush.
  - If granted, head += alloc_num at the next edge. alloc_num=0 gives gnt=1 with no change.
- Release:
  - Each valid lane with rel_tag != ZERO_PR is written at tail in lane order, compacted past invalid or zero lanes; tail += count of such lanes.
  - A tag released in cycle t is allocatable no earlier than cycle t+1 (no bypass).
- Checkpoint:
  - slot[ckpt_id] <= head_next, i.e. head after this cycle's granted allocation. A branch's own destination stays allocated.
  - Same-cycle ckpt_take and restore to the same slot: restore reads the old value, then the slot is overwritten.
- Restore: head <= slot[restore_id]. Releases in the same cycle still commit (tail advances). Allocation is denied.
- Flush:
  - head <= tail_next - N_FREE; free_count becomes N_FREE next cycle.
  - Flush has priority over restore and ckpt_take; same-cycle releases still commit.
- Overflow:
  - If free_count + release count > N_FREE, ovf_err <= 1 (sticky until reset).
  - Excess releases are dropped; tail saturates at head+N_FREE.
- reset asserted mid-operation discards every pending allocation, release and checkpoint that cycle.
- All state updates happen on the rising edge. Outputs are functions of registered state plus alloc_num, restore and flush.

Decomposition:
- Package fl_pkg: PREG_W=clog2(N_PREG), N_FREE, PTR_W, typedefs preg_t and fl_ptr_t, ZERO_PR.
- One sub-module, fl_ckpt_regs: N_CKPT x PTR_W register file, one write port (take), one read port (restore).
- The FIFO storage and pointer logic stay in free_list_ckpt.

Test Plan:
1. Reset, then alloc_num=2 -> gnt=1, tags 32,33; next cycle free_count=30, free_num=2.
2. Drain to free_count=1, alloc_num=2 -> gnt=0, head unchanged; alloc_num=1 -> tag 63, free_count=0, free_num=0.
3. From empty, rel_valid=2'b11 with tags 5,0 -> only 5 written, free_count=1 next cycle; alloc_num=1 the cycle after -> tag 5.
4. After reset: alloc 2 (32,33) with ckpt_take id=1; alloc 2 more (34,35); restore id=1 -> free_count=30 next cycle; next alloc returns 34,35.
5. After 6 allocations, flush together with a release of tag 7 -> free_count=32 next cycle; ovf_err stays 0.
6. At free_count=32, release tag 9 -> ovf_err=1, free_count stays 32; ovf_err held until reset.
